// File: rtl/traffic_pkg.sv
// Shared types and default phase tables for the traffic-light phase sequencer.
// Durations are packed with phase 0 in the least significant field.
package traffic_pkg;

    typedef enum logic {
        MODE_NORM = 1'b0,
        MODE_PED  = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_CNT_W      = 6;
    localparam int DEF_NUM_PHASES = 8;

    localparam logic [DEF_NUM_PHASES*DEF_CNT_W-1:0] DUR_NORM_DEF =
        {6'd0, 6'd0, 6'd2, 6'd2, 6'd8, 6'd2, 6'd2, 6'd15};
    localparam logic [3:0] NPH_NORM_DEF = 4'd6;

    localparam logic [DEF_NUM_PHASES*DEF_CNT_W-1:0] DUR_PED_DEF =
        {6'd0, 6'd2, 6'd10, 6'd2, 6'd6, 6'd2, 6'd2, 6'd11};
    localparam logic [3:0] NPH_PED_DEF = 4'd7;

endpackage

// File: rtl/ped_req_latch.sv
// Sticky pedestrian request; take_o is the request seen by a cycle starting this edge.
// Latency: a request is visible on take_o in the same clk; consume clears it next edge.
// Backpressure: none; repeated requests before consumption collapse into one.
module ped_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic consume_i,
    output logic take_o
);

    logic pending_q;
    logic pending_d;

    assign take_o = pending_q | req_i;

    // A request arriving on the consuming edge is served by that cycle, not kept.
    always_comb begin
        pending_d = consume_i ? 1'b0 : take_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Runtime-configurable phase sequencer: one-clk enable on every phase entry.
// Latency: pulses are registered, appearing the edge after the deciding tick.
// Backpressure: run=0 freezes counter/phase/remaining; pedestrian requests still latch.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int  CNT_W      = 6,
    parameter int  NUM_PHASES = 8,
    localparam int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        ped_req,
    input  logic [NUM_PHASES*CNT_W-1:0] dur_norm,
    input  logic [NUM_PHASES*CNT_W-1:0] dur_ped,
    input  logic [PH_W:0]               nph_norm,
    input  logic [PH_W:0]               nph_ped,
    output logic [CNT_W-1:0]            counter,
    output logic [PH_W-1:0]             phase,
    output logic                        enable,
    output logic                        ped_mode,
    output logic                        ped_ack,
    output logic                        cycle_done
);

    state_e            state_q,   state_d;
    mode_e             mode_q,    mode_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [CNT_W-1:0]  rem_q,     rem_d;
    logic [PH_W-1:0]   phase_q,   phase_d;
    logic [PH_W:0]     nph_q,     nph_d;
    logic              enable_q,  enable_d;
    logic              ack_q,     ack_d;
    logic              done_q,    done_d;
    logic              start;
    logic              take;

    // Phase length with a zero duration promoted to a single tick.
    function automatic logic [CNT_W-1:0] dur_sel(input mode_e m, input logic [PH_W:0] idx);
        logic [CNT_W-1:0] d;
        d = (m == MODE_PED) ? dur_ped[int'(idx)*CNT_W +: CNT_W]
                            : dur_norm[int'(idx)*CNT_W +: CNT_W];
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    function automatic logic [PH_W:0] clamp_nph(input logic [PH_W:0] n);
        if (n == '0) begin
            return (PH_W+1)'(1);
        end
        if (int'(n) > NUM_PHASES) begin
            return (PH_W+1)'(NUM_PHASES);
        end
        return n;
    endfunction

    ped_req_latch u_ped_latch (
        .clk       (clk),
        .rst       (rst),
        .req_i     (ped_req),
        .consume_i (start),
        .take_o    (take)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        phase_d   = phase_q;
        nph_d     = nph_q;
        enable_d  = 1'b0;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        start     = 1'b0;

        unique case (state_q)
            ST_IDLE: start = run;
            ST_RUN: begin
                if (run) begin
                    if (counter_q != '1) begin
                        counter_d = counter_q + 1'b1;
                    end
                    rem_d = rem_q - 1'b1;
                    if (rem_q <= CNT_W'(1)) begin
                        if ({1'b0, phase_q} == nph_q - 1'b1) begin
                            done_d = 1'b1;
                            start  = 1'b1;
                        end else begin
                            phase_d  = phase_q + 1'b1;
                            enable_d = 1'b1;
                            rem_d    = dur_sel(mode_q, {1'b0, phase_q} + 1'b1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Cycle start overrides the tick update; back-to-back cycles have no idle gap.
        if (start) begin
            state_d   = ST_RUN;
            mode_d    = take ? MODE_PED : MODE_NORM;
            ack_d     = take;
            counter_d = '0;
            phase_d   = '0;
            enable_d  = 1'b1;
            nph_d     = clamp_nph(take ? nph_ped : nph_norm);
            rem_d     = dur_sel(mode_d, '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_NORM;
            counter_q <= '0;
            rem_q     <= '0;
            phase_q   <= '0;
            nph_q     <= '0;
            enable_q  <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            phase_q   <= phase_d;
            nph_q     <= nph_d;
            enable_q  <= enable_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign counter    = counter_q;
    assign phase      = phase_q;
    assign enable     = enable_q;
    assign ped_mode   = (mode_q == MODE_PED);
    assign ped_ack    = ack_q;
    assign cycle_done = done_q;

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
Parametrised phase sequencer for the traffic-light controller. It replaces the fixed-boundary enable decoder, whose phase boundaries were hardwired to counter constants. Per-phase durations and phase counts come from runtime configuration inputs for two modes, normal and pedestrian. The block owns its own cycle counter, latches pedestrian requests, and emits a one-clock `enable` pulse at every phase boundary to the light-state FSM downstream.

Parameters:
- CNT_W, 6, width of the cycle counter and of each phase duration.
- NUM_PHASES, 8, maximum number of phases per cycle.
- PH_W (localparam), max(1, $clog2(NUM_PHASES)), width of phase index and phase count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  tick qualifier; block advances one tick per clk while high.
- ped_req  in  1  pedestrian request; single-cycle or level.
- dur_norm  in  NUM_PHASES*CNT_W  normal-mode durations; phase i at [i*CNT_W +: CNT_W].
- dur_ped  in  NUM_PHASES*CNT_W  pedestrian-mode durations; same packing.
- nph_norm  in  PH_W+1  phase count for normal mode.
- nph_ped  in  PH_W+1  phase count for pedestrian mode.
- counter  out  CNT_W  ticks elapsed in current cycle.
- phase  out  PH_W  current phase index.
- enable  out  1  one-clk pulse on entering any phase, including phase 0.
- ped_mode  out  1  mode of the current cycle (1 = pedestrian).
- ped_ack  out  1  one-clk pulse when a pending request is consumed.
- cycle_done  out  1  one-clk pulse on the edge that ends the last phase.

Behaviour:
- Clock and reset: single clock domain. `rst` is synchronous and active-high.
- Reset values: all outputs 0. Internal ped_pending = 0. FSM in IDLE.
- States:
  - IDLE: outputs held at reset values.
  - RUN: sequencing active.
- IDLE to RUN: on the first clk with run=1, perform a cycle start.
- Cycle start (single edge):
  - ped_mode <= ped_pending | ped_req.
  - ped_ack pulses if that value is 1; ped_pending is cleared.
  - counter <= 0, phase <= 0, enable pulses.
  - Sample and hold the active phase count for the whole cycle.
  - Load remaining <= dur[0] of the selected mode.
- RUN with run=1, each clk:
  - counter increments, saturating at 2^CNT_W-1; no wrap inside a cycle.
  - remaining decrements.
  - When remaining reaches 1 on this tick and phase < count-1: phase++, enable pulses, remaining <= dur[phase+1].
  - When remaining reaches 1 on this tick and phase == count-1: cycle_done pulses and a cycle start happens on the same edge. The counter therefore wraps to 0 with no idle gap.
- RUN with run=0:
  - counter, phase and remaining frozen.
  - No enable or cycle_done pulses.
  - ped_req is still latched into ped_pending.
- Phase length: each phase lasts max(dur,1) ticks; duration 0 is treated as 1.
- Phase-count clamp: count 0 is treated as 1; count > NUM_PHASES is clamped to NUM_PHASES.
- Pulse width: `enable`, `ped_ack` and `cycle_done` are registered and high for exactly one clk, even if run drops in that clk.
- Config sampling:
  - Durations are sampled when a phase is loaded; mid-phase changes apply to later phases only.
  - Phase counts are sampled at cycle start only.
- ped_req while ped_mode=1: sets ped_pending for the next cycle. Repeated requests collapse to one.
- ped_req on the cycle-start edge: consumed immediately by that cycle.
- rst mid-operation: returns to IDLE next edge, discarding pending requests. rst has priority over everything.

Decomposition:
- Shared package traffic_pkg holds:
  - mode_e {MODE_NORM, MODE_PED}.
  - state_e {ST_IDLE, ST_RUN}.
  - Default duration constants:
    - normal {15,2,2,8,2,2}, count 6.
    - pedestrian {11,2,2,6,2,10,2}, count 7.
- One sub-module, ped_req_latch, implements the sticky request plus consume/ack handshake.
- Duration select is an inline mux; it is not a separate sub-module.

Test Plan:
- Default normal config, run=1 continuous, no ped_req -> enable at counter 0,15,17,19,27,29; cycle_done at tick 31; counter wraps to 0 with phase 0.
- ped_req pulse at counter 5 of a normal cycle -> normal cycle completes. Next cycle: ped_mode=1, ped_ack at its start, enable at 0,11,13,15,21,23,33, length 35. Following cycle returns to normal.
- run=0 for 10 clk at counter 16 (phase 1) -> counter/phase hold at 16/1 with no pulses. After resume, enable at counter 17 with phase 2.
- rst asserted at counter 20 of a pedestrian cycle with ped_pending set -> next edge all outputs 0 and FSM in IDLE. After rst release with run=1 and ped_req low, the first cycle has ped_mode=0.
- Normal durations {3,0,2}, nph_norm=3 -> enable at 0,3,4; cycle length 6. With nph_norm=0, every cycle is single-phase: enable and cycle_done every dur[0]=3 ticks.
- ped_req asserted exactly on the cycle_done edge -> the new cycle starts with ped_mode=1 and ped_ack on that edge. Separately, durations all 63 with count 8 -> counter saturates at 63 while enable pulses continue per phase.
